// File: rtl/rr_mux_pkg.sv
// Shared types and constants for the round-robin 4:1 mux arbiter.
// Burst locking is enabled by defining RR_BURST_LOCK_EN (see rr_mux_arbiter).
package rr_mux_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  function automatic logic [SEL_W-1:0] rot_next(input logic [SEL_W-1:0] ptr);
    return ptr + SEL_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first eligible requester at or after ptr,
// wrapping modulo NREQ.
module rr_pick4
  import rr_mux_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [NREQ-1:0]  lock_mask,
  output logic [SEL_W-1:0] win,
  output logic             found
);

  logic [NREQ-1:0]  elig;
  logic [SEL_W-1:0] idx;

  always_comb begin
    elig  = req & lock_mask;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter feeding a registered 4:1 DW-bit valid/ready output stage.
// Define RR_BURST_LOCK_EN to add req_last and hold the grant across a burst.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
`ifdef RR_BURST_LOCK_EN
  input  logic [NREQ-1:0]    req_last,
`endif
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic [NREQ-1:0]    out_grant,
  input  logic               out_ready
);

  lock_state_e      state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] lock_id_q, lock_id_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [NREQ-1:0]  out_grant_q, out_grant_d;

  logic [NREQ-1:0]  lock_mask;
  logic [SEL_W-1:0] win;
  logic             found;
  logic             can_load;
  logic             accept;
  logic             beat_last;
  logic [DW-1:0]    sel_data;

  // While locked only the burst owner may win, even if it is momentarily idle.
  assign lock_mask = (state_q == LOCKED) ? (NREQ'(1) << lock_id_q) : '1;

  rr_pick4 u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .lock_mask (lock_mask),
    .win       (win),
    .found     (found)
  );

  assign can_load  = !out_valid_q || out_ready;
  assign accept    = can_load && found && !rst;
  assign req_ready = accept ? (NREQ'(1) << win) : '0;

`ifdef RR_BURST_LOCK_EN
  assign beat_last = req_last[win];
`else
  assign beat_last = 1'b1;
`endif

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == SEL_W'(i)) sel_data = req_data[DW*i +: DW];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_id_d   = lock_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_grant_d = out_grant_q;
    if (can_load) begin
      if (found) begin
        out_valid_d = 1'b1;
        out_data_d  = sel_data;
        out_sel_d   = win;
        out_grant_d = NREQ'(1) << win;
        // Pointer only rotates when a burst (or single beat) completes.
        if (beat_last) begin
          state_d = UNLOCKED;
          ptr_d   = rot_next(win);
        end else begin
          state_d   = LOCKED;
          lock_id_d = win;
        end
      end else begin
        out_valid_d = 1'b0;
        out_grant_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      ptr_q       <= '0;
      lock_id_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_grant_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_id_q   <= lock_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_grant_q <= out_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_grant = out_grant_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: a round-robin reference model predicts
// each accepted beat; a negedge monitor retires predictions on output handshakes.
module tb_rr_mux_arbiter;

  localparam int DW = 4;
  localparam int NCYC = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]    req_ready;
`ifdef RR_BURST_LOCK_EN
  logic [3:0]    req_last;
`endif
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic [3:0]    out_grant;
  logic          out_ready;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
`ifdef RR_BURST_LOCK_EN
    .req_last  (req_last),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_grant (out_grant),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            sel;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int            ptr = 0;
  bit            locked = 0;
  int            lock_id = 0;
  bit            pipe_full = 0;
  bit            pres[4];
  logic [DW-1:0] pdat[4];
  bit            plast[4];
  int            last_acc = -1;
  bit            did_rst = 0;
  int            rst_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]          = pres[i];
      req_data[DW*i +: DW]  = pdat[i];
`ifdef RR_BURST_LOCK_EN
      req_last[i]           = plast[i];
`endif
    end
  endtask

  // Predict the upcoming edge from the currently presented inputs.
  task automatic model_step();
    int  w;
    bit  can_load;
    bit  accept;
    bit  last;
    logic [3:0] exp_rr;
    beat_t b;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (ptr + k) % 4;
      if (w < 0 && pres[i] && (!locked || i == lock_id)) w = i;
    end
    can_load = !pipe_full || out_ready;
    accept   = can_load && (w >= 0);
    exp_rr   = accept ? 4'(1 << w) : 4'b0000;
    chk("out_valid", 32'(out_valid), 32'(pipe_full));
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    if (accept) begin
      b.data = pdat[w];
      b.sel  = w;
      exp_q.push_back(b);
`ifdef RR_BURST_LOCK_EN
      last = plast[w];
`else
      last = 1'b1;
`endif
      if (last) begin
        locked = 0;
        ptr    = (w + 1) % 4;
      end else begin
        locked  = 1;
        lock_id = w;
      end
      last_acc = w;
    end
    pipe_full = accept || (pipe_full && !out_ready);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(1), 32'(0));
        end else begin
          mon_b = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(mon_b.data));
          chk("out_sel", 32'(out_sel), 32'(mon_b.sel));
          chk("out_grant", 32'(out_grant), 32'(1 << mon_b.sel));
        end
      end else if (!out_valid) begin
        chk("grant_idle", 32'(out_grant), 32'(0));
      end
    end
  end

  initial begin
    int mode;
    for (int i = 0; i < 4; i++) begin
      pres[i]  = 1'b1;
      pdat[i]  = DW'(10 + i);
      plast[i] = 1'b1;
    end
    out_ready = 1'b1;
    drive();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_sel", 32'(out_sel), 32'(0));
    chk("rst_out_grant", 32'(out_grant), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    rst = 1'b0;
    #1;

    for (int c = 0; c < NCYC; c++) begin
      model_step();
      @(posedge clk);
      #1;
      if (last_acc >= 0) pres[last_acc] = 1'b0;
      last_acc = -1;

      if (c < 60) mode = 0;
      else if (c < 80) mode = 1;
      else if (c < 90) mode = 4;
      else if (c < 110) mode = 2;
      else if (!did_rst) mode = 3;
      else if (c < rst_cyc + 20) mode = 1;
      else if (c < NCYC - 20) mode = 0;
      else mode = 4;

      case (mode)
        3:       out_ready = ($urandom_range(0, 3) == 0);
        0:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
      for (int i = 0; i < 4; i++) begin
        if (!pres[i]) begin
          case (mode)
            0, 3: if ($urandom_range(0, 1) == 1) begin
              pres[i]  = 1'b1;
              pdat[i]  = DW'($urandom);
              plast[i] = ($urandom_range(0, 2) != 0);
            end
            1: begin
              pres[i]  = 1'b1;
              pdat[i]  = DW'(10 + i);
              plast[i] = 1'b1;
            end
            2: if (i < 2) begin
              pres[i]  = 1'b1;
              pdat[i]  = DW'($urandom);
              plast[i] = 1'b1;
            end
            default: ;
          endcase
        end
      end
      drive();
      #1;

      // Asynchronous reset mid-stream while a beat sits in the output register.
      if (!did_rst && c >= 125 && pipe_full) begin
        did_rst = 1;
        rst_cyc = c;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'(0));
        chk("async_rst_data", 32'(out_data), 32'(0));
        chk("async_rst_grant", 32'(out_grant), 32'(0));
        chk("async_rst_ready", 32'(req_ready), 32'(0));
        ptr       = 0;
        locked    = 0;
        lock_id   = 0;
        pipe_full = 0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
          if (!pres[i]) begin
            pres[i]  = 1'b1;
            pdat[i]  = DW'(10 + i);
            plast[i] = 1'b1;
          end
        end
        drive();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_after_rst", 32'(req_ready), 32'(1));
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("drained", 32'(exp_q.size()), 32'(0));
    chk("reset_happened", 32'(did_rst), 32'(1));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
